spongent_duplex: RTL and testbench

Sponge-construction core built on the Spongent permutation, used as the duplex engine under the SpongeWrap authenticated-encryption wrapper. Each accepted request optionally XORs one rate block into the state and then runs the full Spongent permutation, one round per clock. The rate part of the state is exposed as the squeezed output. Padding, framing bits and key handling are done by the wrapper, not here.

---
 rtl/spongent_duplex.sv | 107 ++++++++++
 tb/tb_spongent_duplex.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spongent_duplex.sv
// rtl/spongent_duplex.sv - Spongent duplex engine: absorb one rate block, then run the permutation one round per clock.
module spongent_duplex #(
    parameter int RATE         = 18,
    parameter int MIN_CAPACITY = 128
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_continue,
    input  logic            msg_data_available,
    input  logic [RATE-1:0] data_in,
    output logic            busy,
    output logic [RATE-1:0] data_out
);

    localparam int SUM    = RATE + MIN_CAPACITY;
    localparam int WIDTH  = (SUM <= 88) ? 88 : (SUM <= 136) ? 136 : 176;
    localparam int ROUNDS = (WIDTH == 88) ? 45 : (WIDTH == 136) ? 70 : 90;
    localparam int L      = (WIDTH == 88) ? 6 : 7;
    localparam int CW     = $clog2(ROUNDS);
    localparam logic [L-1:0] LC_INIT = (WIDTH == 88)  ? L'(6'h05) :
                                       (WIDTH == 136) ? L'(7'h7A) : L'(7'h45);

    if (SUM > 176) begin : g_size_check
        $error("RATE + MIN_CAPACITY exceeds the largest Spongent state (176)");
    end

    typedef enum logic {IDLE, PERMUTE} state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  s, s_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic [L-1:0]      lc, lc_next;
    logic [WIDTH-1:0]  rc_xor, sb_out, round_out;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hE;  4'h1: sbox = 4'hD;  4'h2: sbox = 4'hB;  4'h3: sbox = 4'h0;
            4'h4: sbox = 4'h2;  4'h5: sbox = 4'h1;  4'h6: sbox = 4'h4;  4'h7: sbox = 4'hF;
            4'h8: sbox = 4'h7;  4'h9: sbox = 4'hA;  4'hA: sbox = 4'h8;  4'hB: sbox = 4'h5;
            4'hC: sbox = 4'h9;  4'hD: sbox = 4'hC;  4'hE: sbox = 4'h3;  default: sbox = 4'h6;
        endcase
    endfunction

    // One Spongent round: counter injection at both ends, S-box layer, bit permutation.
    always_comb begin
        rc_xor = s;
        for (int i = 0; i < L; i++) begin
            rc_xor[i]           = rc_xor[i] ^ lc[i];
            rc_xor[WIDTH-1-i]   = rc_xor[WIDTH-1-i] ^ lc[i];
        end
        sb_out = '0;
        for (int n = 0; n < WIDTH / 4; n++) begin
            sb_out[4*n +: 4] = sbox(rc_xor[4*n +: 4]);
        end
        round_out = '0;
        for (int j = 0; j < WIDTH - 1; j++) begin
            round_out[(j * (WIDTH / 4)) % (WIDTH - 1)] = sb_out[j];
        end
        round_out[WIDTH-1] = sb_out[WIDTH-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            s     <= '0;
            cnt   <= '0;
            lc    <= '0;
        end else begin
            state <= state_next;
            s     <= s_next;
            cnt   <= cnt_next;
            lc    <= lc_next;
        end
    end

    always_comb begin
        state_next = state;
        s_next     = s;
        cnt_next   = cnt;
        lc_next    = lc;
        case (state)
            IDLE: begin
                if (start_continue) begin
                    if (msg_data_available) begin
                        s_next[RATE-1:0] = s[RATE-1:0] ^ data_in;
                    end
                    cnt_next   = '0;
                    lc_next    = LC_INIT;
                    state_next = PERMUTE;
                end
            end
            default: begin
                s_next  = round_out;
                lc_next = {lc[L-2:0], lc[L-1] ^ lc[L-2]};
                if (cnt == CW'(ROUNDS - 1)) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
        endcase
    end

    assign busy     = (state == PERMUTE);
    assign data_out = s[RATE-1:0];

endmodule

// File: tb/tb_spongent_duplex.sv
// tb/tb_spongent_duplex.sv - directed bench for spongent_duplex at default parameters (b=176, 90 rounds).
module tb_spongent_duplex;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_continue = 1'b0;
    logic        msg_data_available = 1'b0;
    logic [17:0] data_in = '0;
    logic        busy;
    logic [17:0] data_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spongent_duplex dut (
        .clk                (clk),
        .reset              (reset),
        .start_continue     (start_continue),
        .msg_data_available (msg_data_available),
        .data_in            (data_in),
        .busy               (busy),
        .data_out           (data_out)
    );

    // Reference Spongent-176: permutation written as a gather (out[p] = in[4p mod 175]).
    function automatic logic [175:0] model_perm(input logic [175:0] s_in);
        logic [175:0] s;
        logic [175:0] t;
        logic [63:0]  sb_tab;
        logic [6:0]   lc;
        s      = s_in;
        lc     = 7'h45;
        sb_tab = 64'h63C958A7F4120BDE;
        for (int r = 0; r < 90; r++) begin
            for (int i = 0; i < 7; i++) begin
                s[i]     = s[i] ^ lc[i];
                s[175-i] = s[175-i] ^ lc[i];
            end
            for (int n = 0; n < 44; n++) begin
                t[4*n +: 4] = sb_tab[{s[4*n +: 4], 2'b00} +: 4];
            end
            for (int p = 0; p < 175; p++) begin
                s[p] = t[(4 * p) % 175];
            end
            s[175] = t[175];
            lc = {lc[5:0], lc[6] ^ lc[5]};
        end
        return s;
    endfunction

    function automatic logic [175:0] absorb(input logic [175:0] s, input logic [17:0] blk);
        logic [175:0] r;
        r = s;
        r[17:0] = r[17:0] ^ blk;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_call(input logic msg, input logic [17:0] blk);
        start_continue     = 1'b1;
        msg_data_available = msg;
        data_in            = blk;
        @(negedge clk);
        start_continue     = 1'b0;
        msg_data_available = 1'b0;
        data_in            = '0;
        t_acc              = cyc;
    endtask

    task automatic wait_idle(output int dur);
        while (busy === 1'b1 && (cyc - t_acc) < 300) @(negedge clk);
        dur = cyc - t_acc;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy_in: got %b expected 0", busy); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (data_out !== 18'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", data_out); end
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || data_out !== 18'h0) begin
            failures++; $display("FAIL reset_quiet: got busy=%b data=%h expected 0/0", busy, data_out);
        end
    endtask

    task automatic test_busy_length();
        logic [175:0] exp;
        int dur;
        do_reset();
        exp = model_perm(absorb('0, 18'h3FFFF));
        start_call(1'b1, 18'h3FFFF);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_start: got %b expected 1", busy); end
        wait_idle(dur);
        checks++;
        if (dur !== 90) begin failures++; $display("FAIL busy_len: got %0d expected 90", dur); end
        checks++;
        if (data_out !== exp[17:0]) begin failures++; $display("FAIL busy_data: got %h expected %h", data_out, exp[17:0]); end
    endtask

    task automatic test_no_absorb();
        logic [175:0] exp;
        logic [17:0]  out0, out1;
        int d0, d1;
        exp = model_perm('0);
        do_reset();
        start_call(1'b0, 18'h12345);
        wait_idle(d0);
        out0 = data_out;
        do_reset();
        start_call(1'b1, 18'h00000);
        wait_idle(d1);
        out1 = data_out;
        checks++;
        if (out0 !== exp[17:0]) begin failures++; $display("FAIL noabs_model: got %h expected %h", out0, exp[17:0]); end
        checks++;
        if (out0 !== out1) begin failures++; $display("FAIL noabs_vs_zero: got %h expected %h", out0, out1); end
        checks++;
        if (d0 !== 90) begin failures++; $display("FAIL noabs_len: got %0d expected 90", d0); end
        checks++;
        if (d0 !== d1) begin failures++; $display("FAIL noabs_len_eq: got %0d expected %0d", d0, d1); end
    endtask

    task automatic test_ignore_busy();
        logic [175:0] exp;
        int dur;
        do_reset();
        exp = model_perm(absorb('0, 18'h00ABC));
        start_call(1'b1, 18'h00ABC);
        repeat (30) @(negedge clk);
        start_continue     = 1'b1;
        msg_data_available = 1'b1;
        data_in            = 18'h12345;
        @(negedge clk);
        start_continue     = 1'b0;
        msg_data_available = 1'b0;
        data_in            = '0;
        wait_idle(dur);
        checks++;
        if (dur !== 90) begin failures++; $display("FAIL ignore_len: got %0d expected 90", dur); end
        checks++;
        if (data_out !== exp[17:0]) begin failures++; $display("FAIL ignore_data: got %h expected %h", data_out, exp[17:0]); end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL ignore_no_queue: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [175:0] ms;
        logic [17:0]  blk;
        int t0, dur;
        do_reset();
        ms = '0;
        t0 = cyc;
        for (int k = 1; k <= 3; k++) begin
            blk = 18'(k);
            ms  = model_perm(absorb(ms, blk));
            start_call(1'b1, blk);
            wait_idle(dur);
            checks++;
            if (data_out !== ms[17:0]) begin
                failures++; $display("FAIL b2b_data_%0d: got %h expected %h", k, data_out, ms[17:0]);
            end
        end
        checks++;
        if ((cyc - t0) !== 273) begin failures++; $display("FAIL b2b_elapsed: got %0d expected 273", cyc - t0); end
    endtask

    task automatic test_mid_reset();
        logic [175:0] exp;
        int dur;
        do_reset();
        start_call(1'b1, 18'h2AAAA);
        repeat (39) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++;
        if (data_out !== 18'h0) begin failures++; $display("FAIL midrst_data: got %h expected 0", data_out); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp = model_perm(absorb('0, 18'h0F0F0));
        start_call(1'b1, 18'h0F0F0);
        wait_idle(dur);
        checks++;
        if (dur !== 90) begin failures++; $display("FAIL midrst_len: got %0d expected 90", dur); end
        checks++;
        if (data_out !== exp[17:0]) begin failures++; $display("FAIL midrst_fresh: got %h expected %h", data_out, exp[17:0]); end
    endtask

    initial begin
        test_reset();
        test_busy_length();
        test_no_absorb();
        test_ignore_busy();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
